// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and default operand widths.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned MUL_AW = 4;
  localparam int unsigned MUL_BW = 3;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the building block of the ripple-carry adder.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_s    = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/rca_n.sv
// Parameterized N-bit ripple-carry adder built from a chain of full-adder cells.
module rca_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fa_cell u_fa (
      .i_a   (a[i]),
      .i_b   (b[i]),
      .i_cin (w_carry[i]),
      .o_s   (s[i]),
      .o_cout(w_carry[i+1])
    );
  end

  assign cout = w_carry[N];

endmodule

// File: rtl/seq_mul_ctrl.sv
// Sequential shift-and-add multiplier: one AW-bit adder, BW iterations per product,
// valid/ready handshakes on both the operand and the result side.
module seq_mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned AW = MUL_AW,
  parameter int unsigned BW = MUL_BW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [AW-1:0]   a,
  input  logic [BW-1:0]   b,
  output logic            done_valid,
  input  logic            done_ready,
  output logic [AW+BW-1:0] c,
  output logic            busy
);

  localparam int unsigned PW = AW + BW;
  localparam int unsigned CW = $clog2(BW + 1);

  state_e          r_state;
  logic [AW-1:0]   r_a;
  logic [PW-1:0]   r_p;
  logic [CW-1:0]   r_cnt;

  state_e          w_state_nxt;
  logic [AW-1:0]   w_a_nxt;
  logic [PW-1:0]   w_p_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  logic [AW-1:0]   w_hi;
  logic [AW-1:0]   w_addend;
  logic [AW-1:0]   w_sum;
  logic            w_cy;
  logic [PW-1:0]   w_p_shift;

  // Upper half of P accumulates the partial product; lower half holds the
  // not-yet-consumed multiplier bits.
  assign w_hi     = r_p[PW-1:BW];
  assign w_addend = r_p[0] ? r_a : '0;

  rca_n #(
    .N(AW)
  ) u_rca (
    .a   (w_hi),
    .b   (w_addend),
    .cin (1'b0),
    .s   (w_sum),
    .cout(w_cy)
  );

  // Carry-out re-enters at the top so no product bit is ever lost.
  if (BW == 1) begin : g_shift_bw1
    assign w_p_shift = {w_cy, w_sum};
  end else begin : g_shift_bwn
    assign w_p_shift = {w_cy, w_sum, r_p[BW-1:1]};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_p_nxt     = r_p;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start_valid) begin
          w_a_nxt     = a;
          w_p_nxt     = {{AW{1'b0}}, b};
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_p_nxt   = w_p_shift;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(BW - 1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_p     <= w_p_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign start_ready = (r_state == ST_IDLE);
  assign done_valid  = (r_state == ST_DONE);
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign c           = done_valid ? r_p : '0;

endmodule
